// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM timing controller: FSM encodings and the
// byte-lane to chip/UB/LB strobe mapping for the two 16-bit chips.
package sram_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Active-low strobes; index 0 is the chip on bits 15:0, index 1 on bits 31:16.
    typedef struct packed {
        logic [1:0] ce_n;
        logic [1:0] ub_n;
        logic [1:0] lb_n;
    } lanes_t;

    localparam lanes_t LANES_OFF  = lanes_t'(6'h3f);
    localparam lanes_t LANES_READ = lanes_t'(6'h00);

    // A chip is enabled only if at least one of its two bytes is written.
    function automatic lanes_t write_lanes(input logic [3:0] be);
        lanes_t l;
        l.lb_n = {~be[2], ~be[0]};
        l.ub_n = {~be[3], ~be[1]};
        l.ce_n = {~(be[3] | be[2]), ~(be[1] | be[0])};
        return l;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Bus-side word-access handshake between the system master and sram_ctrl.
interface sram_ctrl_if #(
    parameter int ADDR_W = 18
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [31:0]       rdata;
    logic              ack;
    logic              busy;

    modport master (output req, we, addr, wdata, be, input rdata, ack, busy);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack, busy);
endinterface

// File: rtl/sram_ctrl.sv
// Timing controller for the dual 256Kx16 asynchronous SRAM pair (one 32-bit word).
// Every pin-side strobe comes straight from a flop so the pads never see glitches.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 18,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_data_in,
    output logic [31:0]       ram_data_out,
    output logic              ram_data_oe,
    output logic [1:0]        ram_ce_n,
    output logic [1:0]        ram_ub_n,
    output logic [1:0]        ram_lb_n,
    output logic              ram_we_n,
    output logic              ram_oe_n
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    logic [1:0]       state;
    logic             is_write;
    logic [CNT_W-1:0] wait_cnt;
    lanes_t           lanes_q;

    assign ram_ce_n = lanes_q.ce_n;
    assign ram_ub_n = lanes_q.ub_n;
    assign ram_lb_n = lanes_q.lb_n;

    // NOTE: sequential state uses non-blocking assignments only, so every strobe
    // and the next state are computed from pre-edge values and update together.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state        <= ST_IDLE;
            is_write     <= 1'b0;
            wait_cnt     <= '0;
            lanes_q      <= LANES_OFF;
            ram_addr     <= '0;
            ram_data_out <= '0;
            ram_data_oe  <= 1'b0;
            ram_we_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            bus.rdata    <= '0;
            bus.ack      <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        state    <= ST_SETUP;
                        bus.busy <= 1'b1;
                        is_write <= bus.we;
                        ram_addr <= bus.addr;
                        if (bus.we) begin
                            lanes_q      <= write_lanes(bus.be);
                            ram_data_out <= bus.wdata;
                            ram_data_oe  <= 1'b1;
                        end else begin
                            lanes_q  <= LANES_READ;
                            ram_oe_n <= 1'b0;
                        end
                    end
                end
                ST_SETUP: begin
                    state    <= ST_ACCESS;
                    wait_cnt <= is_write ? CNT_W'(WR_WAIT - 1) : CNT_W'(RD_WAIT - 1);
                    if (is_write) ram_we_n <= 1'b0;
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        state    <= ST_HOLD;
                        ram_we_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        bus.ack  <= 1'b1;
                        if (!is_write) bus.rdata <= ram_data_in;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Address and data stay put through HOLD for the SRAM hold time.
                    state       <= ST_IDLE;
                    bus.busy    <= 1'b0;
                    lanes_q     <= LANES_OFF;
                    ram_data_oe <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench: two controller builds (WAIT=1/1 and RD=3/WR=2), each on a
// behavioural SRAM with a WE hold checker, compared against a word-array reference.
module tb_sram_ctrl;

    logic clk_50mhz = 1'b0;
    logic reset;
    always #10 clk_50mhz = ~clk_50mhz;

    sram_ctrl_if #(.ADDR_W(18)) bus_a ();
    sram_ctrl_if #(.ADDR_W(18)) bus_b ();

    logic [17:0] addr_a, addr_b;
    logic [31:0] din_a, din_b, dout_a, dout_b;
    logic        doe_a, doe_b, we_n_a, we_n_b, oe_n_a, oe_n_b;
    logic [1:0]  ce_n_a, ce_n_b, ub_n_a, ub_n_b, lb_n_a, lb_n_b;

    sram_ctrl #(.ADDR_W(18), .RD_WAIT(1), .WR_WAIT(1)) dut_a (
        .clk_50mhz(clk_50mhz), .reset(reset), .bus(bus_a),
        .ram_addr(addr_a), .ram_data_in(din_a), .ram_data_out(dout_a),
        .ram_data_oe(doe_a), .ram_ce_n(ce_n_a), .ram_ub_n(ub_n_a),
        .ram_lb_n(lb_n_a), .ram_we_n(we_n_a), .ram_oe_n(oe_n_a)
    );

    sram_ctrl #(.ADDR_W(18), .RD_WAIT(3), .WR_WAIT(2)) dut_b (
        .clk_50mhz(clk_50mhz), .reset(reset), .bus(bus_b),
        .ram_addr(addr_b), .ram_data_in(din_b), .ram_data_out(dout_b),
        .ram_data_oe(doe_b), .ram_ce_n(ce_n_b), .ram_ub_n(ub_n_b),
        .ram_lb_n(lb_n_b), .ram_we_n(we_n_b), .ram_oe_n(oe_n_b)
    );

    // ---------------- behavioural SRAM pair (pin level) ----------------
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [17:0] fall_addr_a, fall_addr_b;
    logic [31:0] fall_data_a, fall_data_b;
    bit          armed_a, armed_b;
    int          we_viol_a = 0, we_viol_b = 0, bus_clash = 0;

    // Undriven pins read back a recognisable float pattern.
    assign din_a = {(!ce_n_a[1] && !oe_n_a) ? mem_a[addr_a[9:0]][31:16] : 16'hA5A5,
                    (!ce_n_a[0] && !oe_n_a) ? mem_a[addr_a[9:0]][15:0]  : 16'hA5A5};
    assign din_b = {(!ce_n_b[1] && !oe_n_b) ? mem_b[addr_b[9:0]][31:16] : 16'hA5A5,
                    (!ce_n_b[0] && !oe_n_b) ? mem_b[addr_b[9:0]][15:0]  : 16'hA5A5};

    function automatic logic [31:0] pin_write(logic [31:0] old, logic [31:0] d, logic [1:0] ce_n,
                                              logic [1:0] ub_n, logic [1:0] lb_n, logic oe);
        logic [31:0] r = old;
        if (oe && !ce_n[0] && !lb_n[0]) r[7:0]   = d[7:0];
        if (oe && !ce_n[0] && !ub_n[0]) r[15:8]  = d[15:8];
        if (oe && !ce_n[1] && !lb_n[1]) r[23:16] = d[23:16];
        if (oe && !ce_n[1] && !ub_n[1]) r[31:24] = d[31:24];
        return r;
    endfunction

    always @(negedge we_n_a) begin fall_addr_a = addr_a; fall_data_a = dout_a; armed_a = doe_a; end
    always @(negedge we_n_b) begin fall_addr_b = addr_b; fall_data_b = dout_b; armed_b = doe_b; end

    always @(posedge we_n_a) if (reset === 1'b0) begin
        if (!armed_a || addr_a !== fall_addr_a || dout_a !== fall_data_a || !doe_a) we_viol_a++;
        mem_a[addr_a[9:0]] = pin_write(mem_a[addr_a[9:0]], dout_a, ce_n_a, ub_n_a, lb_n_a, doe_a);
        armed_a = 1'b0;
    end
    always @(posedge we_n_b) if (reset === 1'b0) begin
        if (!armed_b || addr_b !== fall_addr_b || dout_b !== fall_data_b || !doe_b) we_viol_b++;
        mem_b[addr_b[9:0]] = pin_write(mem_b[addr_b[9:0]], dout_b, ce_n_b, ub_n_b, lb_n_b, doe_b);
        armed_b = 1'b0;
    end

    always @(negedge clk_50mhz)
        if ((doe_a && !oe_n_a) || (doe_b && !oe_n_b)) bus_clash++;

    // ---------------- reference model and checking ----------------
    logic [31:0] ref_a [0:1023];
    logic [31:0] ref_b [0:1023];
    int n_checks = 0, n_pass = 0, n_fail = 0;

    typedef struct packed {
        logic        ack, busy, we_n, oe_n, doe;
        logic [5:0]  lanes;
        logic [17:0] addr;
        logic [31:0] rdata;
    } obs_t;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample(bit sel);
        obs_t o;
        if (sel) o = '{bus_b.ack, bus_b.busy, we_n_b, oe_n_b, doe_b,
                       {ce_n_b, ub_n_b, lb_n_b}, addr_b, bus_b.rdata};
        else     o = '{bus_a.ack, bus_a.busy, we_n_a, oe_n_a, doe_a,
                       {ce_n_a, ub_n_a, lb_n_a}, addr_a, bus_a.rdata};
        return o;
    endfunction

    task automatic drive(bit sel, bit r, bit w, logic [17:0] a, logic [31:0] d, logic [3:0] b);
        if (sel) begin bus_b.req = r; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d; bus_b.be = b; end
        else     begin bus_a.req = r; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d; bus_a.be = b; end
    endtask

    // Expected strobes straight from the byte-lane rules: {ce_n, ub_n, lb_n}.
    function automatic logic [5:0] exp_lanes(bit w, logic [3:0] b);
        if (!w) return 6'b00_00_00;
        return {~(b[3] | b[2]), ~(b[1] | b[0]), ~b[3], ~b[1], ~b[2], ~b[0]};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] b);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic ref_write(bit sel, logic [17:0] a, logic [31:0] d, logic [3:0] b);
        if (sel) ref_b[a[9:0]] = merge(ref_b[a[9:0]], d, b);
        else     ref_a[a[9:0]] = merge(ref_a[a[9:0]], d, b);
    endtask

    // One complete access, starting with the DUT idle; checks timing, strobes and data.
    task automatic run_access(bit sel, bit w, logic [17:0] a, logic [31:0] d, logic [3:0] b,
                              string tag, output logic [31:0] rd);
        int   wt = sel ? (w ? 2 : 3) : 1;
        int   lat = 99, we_lo = 0, oe_lo = 0;
        bit   doe_seen = 1'b0;
        obs_t o;
        logic [31:0] exp_rd = sel ? ref_b[a[9:0]] : ref_a[a[9:0]];
        @(negedge clk_50mhz);
        drive(sel, 1'b1, w, a, d, b);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_50mhz);
            o = sample(sel);
            if (k == 1) begin
                drive(sel, 1'b0, 1'b0, '0, '0, '0);
                check({tag, "_setup_lanes"}, 32'(o.lanes), 32'(exp_lanes(w, b)));
                check({tag, "_setup_addr"}, 32'(o.addr), 32'(a));
                check({tag, "_setup_busy"}, 32'(o.busy), 32'd1);
            end
            if (!o.we_n) we_lo++;
            if (!o.oe_n) oe_lo++;
            if (o.doe)   doe_seen = 1'b1;
            if (o.ack) begin lat = k; break; end
        end
        check({tag, "_ack_latency"}, 32'(lat), 32'(wt + 2));
        rd = o.rdata;
        if (w) begin
            check({tag, "_we_low_cycles"}, 32'(we_lo), 32'(wt));
            ref_write(sel, a, d, b);
        end else begin
            check({tag, "_oe_low_cycles"}, 32'(oe_lo), 32'(wt + 1));
            check({tag, "_read_data_oe"}, 32'(doe_seen), 32'd0);
            check({tag, "_rdata"}, o.rdata, exp_rd);
        end
        @(negedge clk_50mhz);
        o = sample(sel);
        check({tag, "_idle_state"}, {25'd0, o.ack, o.busy, o.doe, o.lanes[5:2]},
              {25'd0, 1'b0, 1'b0, 1'b0, 4'hF});
    endtask

    initial begin : stimulus
        logic [31:0] rd;
        obs_t        o;
        int          acks[$];
        bit          busy_at [1:12];
        int          ack_cnt;

        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0; mem_b[i] = '0; ref_a[i] = '0; ref_b[i] = '0;
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk_50mhz);
        for (int s = 0; s < 2; s++) begin
            o = sample(s[0]);
            check("reset_ctrl", {26'd0, o.ack, o.busy, o.we_n, o.oe_n, o.doe, 1'b0},
                  {26'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
            check("reset_lanes", 32'(o.lanes), 32'h3f);
            check("reset_data", o.rdata | 32'(o.addr), 32'd0);
        end
        reset = 1'b0;

        // Directed sequence on the WAIT=1 build.
        run_access(1'b0, 1'b1, 18'h00010, 32'hDEADBEEF, 4'hF, "wr_full", rd);
        run_access(1'b0, 1'b0, 18'h00010, 32'h0, 4'h0, "rd_full", rd);
        check("rd_full_value", rd, 32'hDEADBEEF);
        run_access(1'b0, 1'b1, 18'h00010, 32'h11223344, 4'b0100, "wr_byte2", rd);
        run_access(1'b0, 1'b0, 18'h00010, 32'h0, 4'h0, "rd_byte2", rd);
        check("rd_byte2_value", rd, 32'hDE22BEEF);

        // req held high across two accesses.
        @(negedge clk_50mhz);
        drive(1'b0, 1'b1, 1'b1, 18'h00020, 32'hCAFEF00D, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_50mhz);
            o = sample(1'b0);
            busy_at[k] = o.busy;
            if (o.ack) begin
                acks.push_back(k);
                if (acks.size() == 1) drive(1'b0, 1'b1, 1'b1, 18'h00021, 32'h0BADC0DE, 4'b0011);
                else                  drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        ref_write(1'b0, 18'h00020, 32'hCAFEF00D, 4'hF);
        ref_write(1'b0, 18'h00021, 32'h0BADC0DE, 4'b0011);
        check("b2b_ack_count", 32'(acks.size()), 32'd2);
        check("b2b_first_ack", 32'(acks.size() > 0 ? acks[0] : 99), 32'd3);
        check("b2b_ack_spacing", 32'(acks.size() > 1 ? acks[1] - acks[0] : 99), 32'd4);
        check("b2b_idle_gap", {30'd0, busy_at[4], busy_at[5]}, 32'b01);
        run_access(1'b0, 1'b0, 18'h00021, 32'h0, 4'h0, "b2b_rd2", rd);

        // Slow build: RD_WAIT=3, WR_WAIT=2.
        run_access(1'b1, 1'b1, 18'h00005, 32'h89ABCDEF, 4'hF, "slow_wr", rd);
        run_access(1'b1, 1'b0, 18'h00005, 32'h0, 4'h0, "slow_rd", rd);
        run_access(1'b1, 1'b1, 18'h00005, 32'hFFFFFFFF, 4'h0, "slow_be0", rd);
        run_access(1'b1, 1'b0, 18'h00005, 32'h0, 4'h0, "slow_be0_rd", rd);
        check("slow_be0_value", rd, 32'h89ABCDEF);

        // Reset while a slow read sits in ACCESS.
        @(negedge clk_50mhz);
        drive(1'b1, 1'b1, 1'b0, 18'h00005, '0, '0);
        @(negedge clk_50mhz);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk_50mhz);
        reset = 1'b1;
        @(negedge clk_50mhz);
        o = sample(1'b1);
        check("rst_mid_ctrl", {27'd0, o.ack, o.busy, o.we_n, o.oe_n, o.doe},
              {27'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("rst_mid_lanes", 32'(o.lanes), 32'h3f);
        reset = 1'b0;
        ack_cnt = 0;
        repeat (8) begin
            @(negedge clk_50mhz);
            if (bus_b.ack) ack_cnt++;
        end
        check("rst_mid_no_ack", 32'(ack_cnt), 32'd0);
        run_access(1'b1, 1'b0, 18'h00005, 32'h0, 4'h0, "rst_after_rd", rd);

        // Randomized mix on both builds against the reference arrays.
        for (int i = 0; i < 24; i++) begin
            bit          sel = 1'($urandom_range(0, 1));
            bit          w   = 1'($urandom_range(0, 1));
            logic [17:0] a   = 18'($urandom_range(0, 31));
            run_access(sel, w, a, $urandom, 4'($urandom), "rand", rd);
        end

        check("we_hold_a", 32'(we_viol_a), 32'd0);
        check("we_hold_b", 32'(we_viol_b), 32'd0);
        check("bus_clash", 32'(bus_clash), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
